seg_scan_ctrl: RTL and testbench

Display controller for the 4-digit seven-segment display driven by the pulse-counting datapath. Accepts a 14-bit binary count on a load strobe, converts it to four BCD digits with a sequential shift-add-3 engine, then time-multiplexes the digits onto the shared `an`/`seg` pins at a programmable refresh rate. Supports optional leading-zero blanking and shows `----` when the count is out of range.

---
 rtl/seg_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// 4-digit seven-segment controller: binary load -> BCD (shift-add-3), then multiplexed scan.
// Latency: 15 cycles load-to-display register, an/seg registered. No backpressure; loads while busy are dropped.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [13:0] value,
    input  logic        load,
    input  logic        blank_lz,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int PW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t        state;
    logic [13:0]   bin_q;
    logic [15:0]   bcd_q;
    logic [3:0]    iter_q;
    logic          over_q;
    logic [15:0]   disp_q;
    logic          disp_over_q;

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [3:0]    digit;
    logic          zero_above;
    logic [3:0]    slot_an;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;

    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int k = 0; k < 4; k++) begin
            if (b[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = b[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Conversion engine; the display register only changes in COMMIT so the scan never sees partial digits
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bin_q       <= '0;
            bcd_q       <= '0;
            iter_q      <= '0;
            over_q      <= 1'b0;
            disp_q      <= '0;
            disp_over_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_q  <= value;
                        bcd_q  <= '0;
                        over_q <= (value > 14'd9999);
                        iter_q <= '0;
                        state  <= SHIFT;
                        busy   <= 1'b1;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {add3(bcd_q), bin_q} << 1;
                    iter_q         <= iter_q + 4'd1;
                    if (iter_q == 4'd13) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp_q      <= bcd_q;
                    disp_over_q <= over_q;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        digit = 4'd0;
        case (idx)
            2'd0: digit = disp_q[3:0];
            2'd1: digit = disp_q[7:4];
            2'd2: digit = disp_q[11:8];
            2'd3: digit = disp_q[15:12];
            default: digit = 4'd0;
        endcase
        // This digit and every more significant one are zero
        zero_above = ((disp_q >> {idx, 2'b00}) == 16'd0);
        slot_an    = ~(4'b0001 << idx);

        an_nxt  = slot_an;
        seg_nxt = decode(digit);
        if (disp_over_q) begin
            seg_nxt = 7'b0111111;
        end else if (blank_lz && (idx != 2'd0) && zero_above) begin
            an_nxt  = 4'b1111;
            seg_nxt = 7'b1111111;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc <= '0;
            idx   <= 2'd0;
            an    <= 4'b1111;
            seg   <= 7'b1111111;
        end else begin
            if (presc == PW'(REFRESH_DIV - 1)) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: decimal-arithmetic reference model checked every cycle, directed scenarios, random loads/resets.
module tb_seg_scan_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] value = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .value    (value),
        .load     (load),
        .blank_lz (blank_lz),
        .busy     (busy),
        .an       (an),
        .seg      (seg)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input int d);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    function automatic int pow10(input int i);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        return p;
    endfunction

    // Reference model: decimal value on display, cycles left in a conversion, cycles since reset
    int         m_disp, m_pend, m_cnt, m_k, m_slot;
    bit         m_over, m_pend_over, m_busy;
    bit         m_valid = 1'b0;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_disp = 0; m_over = 0; m_cnt = 0; m_k = 0; m_busy = 0;
            m_an = 4'b1111; m_seg = 7'b1111111;
            m_valid = 1'b1;
        end else begin
            m_slot = (m_k / DIV) % 4;
            if (m_over) begin
                m_an  = ~(4'b0001 << m_slot);
                m_seg = 7'b0111111;
            end else if (blank_lz && m_slot != 0 && m_disp < pow10(m_slot)) begin
                m_an  = 4'b1111;
                m_seg = 7'b1111111;
            end else begin
                m_an  = ~(4'b0001 << m_slot);
                m_seg = dec((m_disp / pow10(m_slot)) % 10);
            end
            m_k++;
            if (m_cnt == 0) begin
                if (load) begin
                    m_pend      = int'(value);
                    m_pend_over = (int'(value) > 9999);
                    m_cnt       = 15;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_disp = m_pend;
                    m_over = m_pend_over;
                end
            end
            m_busy = (m_cnt > 0);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_an",   int'(an),   int'(m_an));
            check("model_seg",  int'(seg),  int'(m_seg));
            check("model_busy", int'(busy), int'(m_busy));
        end
    end

    logic [6:0] seen [4];
    int         blanks;

    task automatic do_load(input int v, input bit bl);
        value    = 14'(v);
        blank_lz = bl;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic collect();
        logic [3:0] ea;
        blanks = 0;
        for (int i = 0; i < 4; i++) seen[i] = 7'h55;
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            if (an == 4'b1111) blanks++;
            for (int i = 0; i < 4; i++) begin
                ea = ~(4'b0001 << i);
                if (an == ea) seen[i] = seg;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        logic [3:0] ea;

        repeat (3) @(negedge clk);
        check("reset_an",   int'(an),   4'b1111);
        check("reset_seg",  int'(seg),  7'b1111111);
        check("reset_busy", int'(busy), 0);

        reset_n = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            ea = ~(4'b0001 << (j / 4));
            check("scan_an",  int'(an),  int'(ea));
            check("scan_seg", int'(seg), 7'b1000000);
        end

        do_load(1234, 1'b0);
        wait_idle(n);
        check("busy_len_1234", n, 15);
        collect();
        check("d1234_s0", int'(seen[0]), 7'b0011001);
        check("d1234_s1", int'(seen[1]), 7'b0110000);
        check("d1234_s2", int'(seen[2]), 7'b0100100);
        check("d1234_s3", int'(seen[3]), 7'b1111001);

        do_load(7, 1'b1);
        wait_idle(n);
        collect();
        check("d7_s0", int'(seen[0]), 7'b1111000);
        check("d7_blanks", blanks, 12);

        do_load(0, 1'b1);
        wait_idle(n);
        collect();
        check("d0_s0", int'(seen[0]), 7'b1000000);
        check("d0_blanks", blanks, 12);

        do_load(1005, 1'b1);
        wait_idle(n);
        collect();
        check("d1005_blanks", blanks, 0);
        check("d1005_s2", int'(seen[2]), 7'b1000000);
        check("d1005_s3", int'(seen[3]), 7'b1111001);

        do_load(9999, 1'b0);
        wait_idle(n);
        collect();
        for (int i = 0; i < 4; i++) check("d9999", int'(seen[i]), 7'b0010000);

        do_load(12000, 1'b1);
        wait_idle(n);
        collect();
        for (int i = 0; i < 4; i++) check("over_dash", int'(seen[i]), 7'b0111111);
        check("over_blanks", blanks, 0);

        blank_lz = 1'b0;
        do_load(42, 1'b0);
        repeat (4) @(negedge clk);
        value = 14'd999;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        wait_idle(n);
        check("busy_rest_42", n, 10);
        collect();
        check("d42_s0", int'(seen[0]), 7'b0100100);
        check("d42_s1", int'(seen[1]), 7'b0011001);
        check("d42_s2", int'(seen[2]), 7'b1000000);

        do_load(999, 1'b0);
        wait_idle(n);
        check("busy_len_999", n, 15);
        collect();
        check("d999_s2", int'(seen[2]), 7'b0010000);
        check("d999_s3", int'(seen[3]), 7'b1000000);

        do_load(8888, 1'b0);
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_busy", int'(busy), 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midreset_busy_after", int'(busy), 0);
        collect();
        for (int i = 0; i < 4; i++) check("midreset_zero", int'(seen[i]), 7'b1000000);

        for (int c = 0; c < 3000; c++) begin
            load  = ($urandom_range(0, 5) == 0);
            value = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 16383))
                                                : 14'($urandom_range(0, 1200));
            if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
            reset_n = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        load    = 1'b0;
        reset_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
